bus_packer: RTL and testbench

- Upstream feeder for bus_fifo.
- Accepts a stream of WIDTH-bit beats over a valid/ready handshake and packs IN_DEPTH consecutive beats into one IN_DEPTH*WIDTH word.
- Pushes each packed word into the FIFO write port, honouring the FIFO's full and almost_full flags.
- A last flag or a flush request closes a partial group, zero-padded, so no data is stranded in the packer.

---
 rtl/sys_defs.sv | 18 +
 rtl/bus_packer.sv | 126 ++++++++++++
 tb/tb_bus_packer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// ---------------------------------------------------------------------------
// sys_defs
// Definitions shared by the bus ingress path: bus_packer and bus_fifo.
// The default bus geometry lives here so that the packer and the FIFO
// cannot disagree on beat width or beats per packed word.
// ---------------------------------------------------------------------------
package sys_defs;

    localparam int BUS_WIDTH    = 32;
    localparam int BUS_IN_DEPTH = 6;

    // Packer FSM: FILL collects beats, PUSH offers the packed word to the FIFO.
    typedef enum logic {
        FILL = 1'b0,
        PUSH = 1'b1
    } packer_state_t;

endpackage

// File: rtl/bus_packer.sv
// ---------------------------------------------------------------------------
// bus_packer
// Packs IN_DEPTH consecutive WIDTH-bit beats into one IN_DEPTH*WIDTH word and
// pushes it into the bus_fifo write port. A beat flagged in_last, or a flush
// pulse, closes a partial group; unused slices are zero.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   in_valid/in_ready  input beat handshake
//   in_data, in_last   beat payload and end-of-group marker
//   flush              close any partial group (single-cycle pulse)
//   fifo_wr_en         write request (PUSH and FIFO not full)
//   fifo_wr_data       packed word, beat k at [k*WIDTH +: WIDTH]
//   fifo_wr_valid      FIFO accepted the write this cycle
//   fifo_almost_full   gates in_ready only (when STALL_ON_AF)
//   fifo_full          holds the write request off
//   word_beats         valid beats in the word being presented
//   word_cnt           packed words accepted since reset (wraps)
//   busy               beats held or a word pending
// ---------------------------------------------------------------------------
module bus_packer
    import sys_defs::*;
#(
    parameter int WIDTH       = BUS_WIDTH,
    parameter int IN_DEPTH    = BUS_IN_DEPTH,
    parameter bit STALL_ON_AF = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_last,
    input  logic                        flush,
    output logic                        fifo_wr_en,
    output logic [IN_DEPTH*WIDTH-1:0]   fifo_wr_data,
    input  logic                        fifo_wr_valid,
    input  logic                        fifo_almost_full,
    input  logic                        fifo_full,
    output logic [$clog2(IN_DEPTH+1)-1:0] word_beats,
    output logic [CNT_W-1:0]            word_cnt,
    output logic                        busy
);

    localparam int IDX_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int WB_W  = $clog2(IN_DEPTH+1);

    packer_state_t     state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WB_W-1:0]   word_beats_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [WIDTH-1:0]  pack_q [IN_DEPTH];

    logic beat_accept;
    logic wr_accept;
    logic group_done;

    // Handshake terms depend on same-cycle FIFO flags, so they stay combinational.
    assign in_ready    = (state_q == FILL) && !(STALL_ON_AF && fifo_almost_full);
    assign fifo_wr_en  = (state_q == PUSH) && !fifo_full;
    assign beat_accept = in_valid && in_ready;
    assign wr_accept   = fifo_wr_en && fifo_wr_valid;
    assign group_done  = (idx_q == IDX_W'(IN_DEPTH-1)) || in_last || flush;

    assign word_beats = word_beats_q;
    assign word_cnt   = word_cnt_q;
    assign busy       = (state_q == PUSH) || (idx_q != '0);

    // NOTE: every output of an always_comb gets a default first, otherwise a
    // path that skips an assignment infers a latch.
    always_comb begin
        fifo_wr_data = '0;
        for (int k = 0; k < IN_DEPTH; k++) begin
            fifo_wr_data[k*WIDTH +: WIDTH] = pack_q[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= FILL;
            idx_q        <= '0;
            word_beats_q <= '0;
            word_cnt_q   <= '0;
            // NOTE: the pack array is reset (not left undefined) because
            // zero padding of short groups relies on unused slices being zero.
            for (int k = 0; k < IN_DEPTH; k++) begin
                pack_q[k] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (beat_accept) begin
                        pack_q[idx_q] <= in_data;
                        if (group_done) begin
                            // idx is left as-is; PUSH clears it on acceptance.
                            state_q      <= PUSH;
                            word_beats_q <= WB_W'(idx_q) + WB_W'(1);
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else if (flush && (idx_q != '0)) begin
                        state_q      <= PUSH;
                        word_beats_q <= WB_W'(idx_q);
                    end
                end
                PUSH: begin
                    // flush is deliberately ignored here.
                    if (wr_accept) begin
                        state_q      <= FILL;
                        idx_q        <= '0;
                        word_beats_q <= '0;
                        word_cnt_q   <= word_cnt_q + CNT_W'(1);
                        for (int k = 0; k < IN_DEPTH; k++) begin
                            pack_q[k] <= '0;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_packer.sv
// ---------------------------------------------------------------------------
// tb_bus_packer
// Directed bench for bus_packer (WIDTH=32, IN_DEPTH=6, STALL_ON_AF=1).
// Inputs change on the falling edge; outputs are checked 1 ns later, so
// every check sees the state left by the previous rising edge.
// ---------------------------------------------------------------------------
module tb_bus_packer;

    localparam int WIDTH    = 32;
    localparam int IN_DEPTH = 6;
    localparam int CNT_W    = 16;
    localparam int WB_W     = $clog2(IN_DEPTH+1);

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic                      in_last;
    logic                      flush;
    logic                      fifo_wr_en;
    logic [IN_DEPTH*WIDTH-1:0] fifo_wr_data;
    logic                      fifo_wr_valid;
    logic                      fifo_almost_full;
    logic                      fifo_full;
    logic [WB_W-1:0]           word_beats;
    logic [CNT_W-1:0]          word_cnt;
    logic                      busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bus_packer #(
        .WIDTH       (WIDTH),
        .IN_DEPTH    (IN_DEPTH),
        .STALL_ON_AF (1'b1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_last          (in_last),
        .flush            (flush),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr_valid    (fifo_wr_valid),
        .fifo_almost_full (fifo_almost_full),
        .fifo_full        (fifo_full),
        .word_beats       (word_beats),
        .word_cnt         (word_cnt),
        .busy             (busy)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the next falling edge, apply inputs, let them settle.
    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l, input logic f);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        flush    = f;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    logic [IN_DEPTH*WIDTH-1:0] exp_word;

    initial begin
        rstn             = 1'b0;
        in_valid         = 1'b0;
        in_data          = '0;
        in_last          = 1'b0;
        flush            = 1'b0;
        fifo_wr_valid    = 1'b1;
        fifo_almost_full = 1'b0;
        fifo_full        = 1'b0;

        // ---- reset state
        @(negedge clk);
        #1;
        check("rst_in_ready",   in_ready,   1);
        check("rst_wr_en",      fifo_wr_en, 0);
        check("rst_word_beats", word_beats, 0);
        check("rst_word_cnt",   word_cnt,   0);
        check("rst_busy",       busy,       0);
        check("rst_wr_data",    fifo_wr_data, 0);
        @(negedge clk);
        rstn = 1'b1;

        // ---- full group 1..6
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
            if (i == 6) check("full_no_early_wr", fifo_wr_en, 0);
        end
        idle();
        exp_word = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        check("full_wr_en",      fifo_wr_en,   1);
        check("full_wr_data",    fifo_wr_data, exp_word);
        check("full_word_beats", word_beats,   6);
        check("full_in_ready",   in_ready,     0);
        check("full_busy",       busy,         1);
        check("full_cnt_before", word_cnt,     0);
        idle();
        check("full_cnt_after",  word_cnt,     1);
        check("full_wr_en_done", fifo_wr_en,   0);
        check("full_busy_done",  busy,         0);

        // ---- partial group A, B(last)
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b1, 1'b0);
        idle();
        exp_word = {128'h0, 32'hB, 32'hA};
        check("part_wr_en",      fifo_wr_en,   1);
        check("part_wr_data",    fifo_wr_data, exp_word);
        check("part_word_beats", word_beats,   2);
        idle();
        check("part_cnt",        word_cnt,     2);

        // ---- flush after 3 beats and an idle cycle
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        idle();
        check("flush_idle_busy",  busy,       1);
        check("flush_idle_wr_en", fifo_wr_en, 0);
        drive(1'b0, '0, 1'b0, 1'b1);
        idle();
        exp_word = {96'h0, 32'h33, 32'h22, 32'h11};
        check("flush_wr_en",      fifo_wr_en,   1);
        check("flush_wr_data",    fifo_wr_data, exp_word);
        check("flush_word_beats", word_beats,   3);
        idle();
        check("flush_cnt",        word_cnt,     3);

        // ---- flush with empty packer is a no-op
        drive(1'b0, '0, 1'b0, 1'b1);
        idle();
        check("flush_empty_wr_en", fifo_wr_en, 0);
        check("flush_empty_busy",  busy,       0);
        idle();
        check("flush_empty_wr_en2", fifo_wr_en, 0);
        check("flush_empty_cnt",    word_cnt,   3);

        // ---- FIFO full during PUSH for 10 cycles
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 32'h100 + WIDTH'(i), 1'b0, 1'b0);
        end
        exp_word = {32'h106, 32'h105, 32'h104, 32'h103, 32'h102, 32'h101};
        fifo_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 32'hBAD, 1'b0, 1'b0);
            check("ff_wr_en",    fifo_wr_en,   0);
            check("ff_in_ready", in_ready,     0);
            check("ff_wr_data",  fifo_wr_data, exp_word);
        end
        idle();
        fifo_full = 1'b0;
        #1;
        check("ff_release_wr_en", fifo_wr_en, 1);
        check("ff_release_cnt",   word_cnt,   3);
        check("ff_release_data",  fifo_wr_data, exp_word);
        idle();
        check("ff_cnt_after",     word_cnt,   4);
        check("ff_single_write",  fifo_wr_en, 0);

        // ---- almost-full stalls input mid-group, not a pending push
        drive(1'b1, 32'h51, 1'b0, 1'b0);
        drive(1'b1, 32'h52, 1'b0, 1'b0);
        @(negedge clk);
        fifo_almost_full = 1'b1;
        in_data = 32'h53;
        #1;
        check("af_in_ready", in_ready, 0);
        drive(1'b1, 32'h53, 1'b0, 1'b0);
        check("af_hold_ready", in_ready, 0);
        check("af_hold_busy",  busy,     1);
        @(negedge clk);
        fifo_almost_full = 1'b0;
        #1;
        check("af_resume_ready", in_ready, 1);
        drive(1'b1, 32'h54, 1'b0, 1'b0);
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        drive(1'b1, 32'h56, 1'b0, 1'b0);
        idle();
        fifo_almost_full = 1'b1;
        #1;
        exp_word = {32'h56, 32'h55, 32'h54, 32'h53, 32'h52, 32'h51};
        check("af_push_wr_en", fifo_wr_en,   1);
        check("af_push_data",  fifo_wr_data, exp_word);
        idle();
        check("af_push_cnt",   word_cnt,     5);
        check("af_fill_ready", in_ready,     0);
        fifo_almost_full = 1'b0;
        #1;
        check("af_clear_ready", in_ready,    1);

        // ---- reset mid-operation after 4 beats
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'hDEAD0000 + WIDTH'(i), 1'b0, 1'b0);
        end
        idle();
        rstn = 1'b0;
        #1;
        check("mrst_wr_en",      fifo_wr_en, 0);
        check("mrst_busy",       busy,       0);
        check("mrst_word_cnt",   word_cnt,   0);
        check("mrst_word_beats", word_beats, 0);
        check("mrst_in_ready",   in_ready,   1);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 32'h60 + WIDTH'(i), 1'b0, 1'b0);
        end
        idle();
        exp_word = {32'h66, 32'h65, 32'h64, 32'h63, 32'h62, 32'h61};
        check("mrst_clean_wr_en", fifo_wr_en,   1);
        check("mrst_clean_data",  fifo_wr_data, exp_word);
        check("mrst_clean_beats", word_beats,   6);
        idle();
        check("mrst_clean_cnt",   word_cnt,     1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
